im_port_arbiter: RTL and testbench

- Shares the single-port, word-addressed instruction memory between two requesters:
  - the IF-stage fetch unit (F);
  - the program loader/debug port (L).
- Translates byte addresses based at BASE_ADDR into memory word indices and rejects misaligned or out-of-range accesses.
- Guarantees the loader bounded waiting under continuous fetch traffic.
- Sits between the PC/IF logic and the instruction RAM.

---
 rtl/im_port_arbiter.sv | 121 ++++++++++++
 tb/tb_im_port_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/im_port_arbiter.sv
// -----------------------------------------------------------------------------
// im_port_arbiter
//   Shares the single-port, word-addressed instruction RAM between the IF-stage
//   fetch unit (F) and the program loader / debug port (L). Byte addresses based
//   at BASE_ADDR are translated to word indices; misaligned or out-of-range
//   accesses are granted and consumed but never reach the RAM, and they answer
//   with err=1. F normally wins conflicts, but after STARVE_LIMIT consecutive
//   lost conflicts L wins the next one.
//
// Ports
//   clk, reset          clock (rising edge), async active-low reset
//   f_req/f_addr        fetch read request and byte address
//   f_gnt               fetch accepted this cycle (combinational)
//   f_rvalid/rdata/err  fetch response, one cycle after accept
//   l_req/l_we/l_addr/l_wdata  loader request (read or write)
//   l_gnt               loader accepted this cycle (combinational)
//   l_rvalid/rdata/err  loader response/ack, one cycle after accept
//   mem_en/we/addr/wdata  RAM control, same cycle as the grant
//   mem_rdata           RAM read data, valid the cycle after mem_en
// -----------------------------------------------------------------------------
module im_port_arbiter #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_3000,
    parameter int          DEPTH_LOG2   = 12,
    parameter int          STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  f_req,
    input  logic [31:0]           f_addr,
    output logic                  f_gnt,
    output logic                  f_rvalid,
    output logic [31:0]           f_rdata,
    output logic                  f_err,
    input  logic                  l_req,
    input  logic                  l_we,
    input  logic [31:0]           l_addr,
    input  logic [31:0]           l_wdata,
    output logic                  l_gnt,
    output logic                  l_rvalid,
    output logic [31:0]           l_rdata,
    output logic                  l_err,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [DEPTH_LOG2-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);

    localparam logic [3:0] LIMIT = STARVE_LIMIT[3:0];

    logic [3:0]  r_starve_cnt;
    logic        r_f_pend;     // response owed to F next cycle
    logic        r_l_pend;     // response owed to L next cycle
    logic        r_err;        // registered address-check result
    logic        r_rd;         // accepted access was a valid read

    logic        w_conflict;
    logic        w_any;
    logic [31:0] w_addr;
    logic [31:0] w_off;
    logic [31:0] w_word;
    logic        w_misalign;
    logic        w_below;
    logic        w_oor;
    logic        w_err;

    // ---------------- arbitration ----------------
    assign w_conflict = f_req & l_req;
    assign w_any      = f_req | l_req;
    // L wins when alone, or when it has lost LIMIT conflicts in a row.
    assign l_gnt      = l_req & (~f_req | (r_starve_cnt == LIMIT));
    assign f_gnt      = f_req & ~l_gnt;

    // ---------------- address check on the granted requester ----------------
    assign w_addr     = l_gnt ? l_addr : f_addr;
    assign w_off      = w_addr - BASE_ADDR;
    assign w_word     = {2'b00, w_off[31:2]};
    assign w_misalign = (w_addr[1:0] != 2'b00);
    assign w_below    = (w_addr < BASE_ADDR);
    // Any word-index bit at or above DEPTH_LOG2 means past the end of the RAM.
    assign w_oor      = ((w_word >> DEPTH_LOG2) != 32'd0);
    assign w_err      = w_misalign | w_below | w_oor;

    // ---------------- memory side ----------------
    assign mem_en     = w_any & ~w_err;
    assign mem_we     = w_any & ~w_err & l_gnt & l_we;
    assign mem_addr   = w_word[DEPTH_LOG2-1:0];
    assign mem_wdata  = l_wdata;

    // ---------------- state ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_starve_cnt <= 4'd0;
            r_f_pend     <= 1'b0;
            r_l_pend     <= 1'b0;
            r_err        <= 1'b0;
            r_rd         <= 1'b0;
        end else begin
            r_f_pend <= f_gnt;
            r_l_pend <= l_gnt;
            r_err    <= w_any & w_err;
            r_rd     <= w_any & ~w_err & ~(l_gnt & l_we);
            // Count only conflicts L loses; any L grant or idle L restarts it.
            if (!l_req || l_gnt)
                r_starve_cnt <= 4'd0;
            else if (w_conflict && r_starve_cnt != LIMIT)
                r_starve_cnt <= r_starve_cnt + 4'd1;
        end
    end

    // ---------------- response routing ----------------
    // Only the owner of the in-flight access sees data; writes and errors
    // return zero data.
    assign f_rvalid = r_f_pend;
    assign f_err    = r_f_pend & r_err;
    assign f_rdata  = (r_f_pend && r_rd) ? mem_rdata : 32'd0;
    assign l_rvalid = r_l_pend;
    assign l_err    = r_l_pend & r_err;
    assign l_rdata  = (r_l_pend && r_rd) ? mem_rdata : 32'd0;

endmodule

// File: tb/tb_im_port_arbiter.sv
module tb_im_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        f_req;
    logic [31:0] f_addr;
    logic        f_gnt, f_rvalid, f_err;
    logic [31:0] f_rdata;
    logic        l_req, l_we;
    logic [31:0] l_addr, l_wdata;
    logic        l_gnt, l_rvalid, l_err;
    logic [31:0] l_rdata;
    logic        mem_en, mem_we;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] ram [0:4095];

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    im_port_arbiter dut (
        .clk(clk), .reset(reset),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt),
        .f_rvalid(f_rvalid), .f_rdata(f_rdata), .f_err(f_err),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata), .l_err(l_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Synchronous single-port RAM
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive a request set on the falling edge; combinational outputs settle by #1.
    task automatic drive(input logic fr, input logic [31:0] fa,
                         input logic lr, input logic lw,
                         input logic [31:0] la, input logic [31:0] ld);
        @(negedge clk);
        f_req = fr; f_addr = fa; l_req = lr; l_we = lw; l_addr = la; l_wdata = ld;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = 32'h0;
        ram[0]     = 32'h1111_0000;
        ram[1]     = 32'h2402_0005;
        ram[12'hFFF] = 32'hCAFE_F00D;
        mem_rdata = 32'h0;

        reset = 1'b0;
        f_req = 0; f_addr = 0; l_req = 0; l_we = 0; l_addr = 0; l_wdata = 0;

        // ---- reset state ----
        tick(); tick();
        chk("rst_f_rvalid", {31'b0, f_rvalid}, 32'd0);
        chk("rst_l_rvalid", {31'b0, l_rvalid}, 32'd0);
        chk("rst_f_rdata",  f_rdata, 32'd0);
        chk("rst_l_rdata",  l_rdata, 32'd0);
        chk("rst_errs",     {30'b0, f_err, l_err}, 32'd0);
        chk("rst_mem",      {30'b0, mem_en, mem_we}, 32'd0);
        chk("rst_gnts",     {30'b0, f_gnt, l_gnt}, 32'd0);
        @(negedge clk); reset = 1'b1;

        // ---- fetch read of 0x3004 ----
        drive(1, 32'h3004, 0, 0, 0, 0);
        chk("fr_gnt",   {30'b0, f_gnt, l_gnt}, 32'b10);
        chk("fr_mem",   {30'b0, mem_en, mem_we}, 32'b10);
        chk("fr_addr",  {20'b0, mem_addr}, 32'd1);
        tick();
        chk("fr_rvalid", {30'b0, f_rvalid, l_rvalid}, 32'b10);
        chk("fr_rdata",  f_rdata, 32'h2402_0005);
        chk("fr_err",    {31'b0, f_err}, 32'd0);

        // ---- loader write 0x3010 ----
        drive(0, 0, 1, 1, 32'h3010, 32'hDEAD_BEEF);
        chk("lw_gnt",   {30'b0, f_gnt, l_gnt}, 32'b01);
        chk("lw_mem",   {30'b0, mem_en, mem_we}, 32'b11);
        chk("lw_addr",  {20'b0, mem_addr}, 32'd4);
        chk("lw_wdata", mem_wdata, 32'hDEAD_BEEF);
        tick();
        chk("lw_ack",   {30'b0, f_rvalid, l_rvalid}, 32'b01);
        chk("lw_rdata", l_rdata, 32'd0);
        chk("lw_err",   {31'b0, l_err}, 32'd0);

        // ---- loader read back ----
        drive(0, 0, 1, 0, 32'h3010, 0);
        chk("lr_mem", {30'b0, mem_en, mem_we}, 32'b10);
        tick();
        chk("lr_rvalid", {31'b0, l_rvalid}, 32'd1);
        chk("lr_rdata",  l_rdata, 32'hDEAD_BEEF);
        chk("lr_f_rdata", f_rdata, 32'd0);

        // ---- fetch address errors ----
        drive(1, 32'h3002, 0, 0, 0, 0);
        chk("mis_gnt", {31'b0, f_gnt}, 32'd1);
        chk("mis_mem", {30'b0, mem_en, mem_we}, 32'd0);
        tick();
        chk("mis_resp", {30'b0, f_rvalid, f_err}, 32'b11);
        chk("mis_rdata", f_rdata, 32'd0);

        drive(1, 32'h2FFC, 0, 0, 0, 0);
        chk("low_gnt", {31'b0, f_gnt}, 32'd1);
        chk("low_mem", {31'b0, mem_en}, 32'd0);
        tick();
        chk("low_resp", {30'b0, f_rvalid, f_err}, 32'b11);
        chk("low_rdata", f_rdata, 32'd0);

        drive(1, 32'h7000, 0, 0, 0, 0);
        chk("high_gnt", {31'b0, f_gnt}, 32'd1);
        chk("high_mem", {31'b0, mem_en}, 32'd0);
        tick();
        chk("high_resp", {30'b0, f_rvalid, f_err}, 32'b11);
        chk("high_rdata", f_rdata, 32'd0);

        // ---- last legal word ----
        drive(1, 32'h6FFC, 0, 0, 0, 0);
        chk("top_mem",  {31'b0, mem_en}, 32'd1);
        chk("top_addr", {20'b0, mem_addr}, 32'h0000_0FFF);
        tick();
        chk("top_resp",  {30'b0, f_rvalid, f_err}, 32'b10);
        chk("top_rdata", f_rdata, 32'hCAFE_F00D);

        // ---- loader write out of range: must not touch RAM ----
        drive(0, 0, 1, 1, 32'h7000, 32'h1234_5678);
        chk("lwerr_mem", {30'b0, mem_en, mem_we}, 32'd0);
        tick();
        chk("lwerr_resp", {30'b0, l_rvalid, l_err}, 32'b11);

        // ---- starvation: both held high, pattern F F F F L ----
        for (int i = 0; i < 10; i++) begin
            drive(1, 32'h3000, 1, 0, 32'h3004, 0);
            if (i % 5 == 4) chk($sformatf("stv_gnt%0d", i), {30'b0, f_gnt, l_gnt}, 32'b01);
            else            chk($sformatf("stv_gnt%0d", i), {30'b0, f_gnt, l_gnt}, 32'b10);
            tick();
            if (i % 5 == 4) begin
                chk($sformatf("stv_rv%0d", i), {30'b0, f_rvalid, l_rvalid}, 32'b01);
                chk($sformatf("stv_ld%0d", i), l_rdata, 32'h2402_0005);
            end else begin
                chk($sformatf("stv_rv%0d", i), {30'b0, f_rvalid, l_rvalid}, 32'b10);
                chk($sformatf("stv_fd%0d", i), f_rdata, 32'h1111_0000);
            end
        end

        // ---- pipelined alternation F then L ----
        drive(1, 32'h3004, 0, 0, 0, 0);
        chk("alt_fgnt", {30'b0, f_gnt, l_gnt}, 32'b10);
        tick();
        drive(0, 0, 1, 0, 32'h3010, 0);
        chk("alt_rv1",  {30'b0, f_rvalid, l_rvalid}, 32'b10);
        chk("alt_fd1",  f_rdata, 32'h2402_0005);
        chk("alt_lgnt", {30'b0, f_gnt, l_gnt}, 32'b01);
        tick();
        chk("alt_rv2", {30'b0, f_rvalid, l_rvalid}, 32'b01);
        chk("alt_ld2", l_rdata, 32'hDEAD_BEEF);
        chk("alt_fd2", f_rdata, 32'd0);
        drive(0, 0, 0, 0, 0, 0);
        chk("idle_mem", {30'b0, mem_en, mem_we}, 32'd0);
        tick();
        chk("idle_rv", {30'b0, f_rvalid, l_rvalid}, 32'd0);

        // ---- reset mid-read ----
        drive(1, 32'h3000, 0, 0, 0, 0);
        tick();
        chk("mid_rv_pre", {31'b0, f_rvalid}, 32'd1);
        reset = 1'b0;
        f_req = 1'b0;
        #1;
        chk("mid_rv_rst", {31'b0, f_rvalid}, 32'd0);
        chk("mid_rd_rst", f_rdata, 32'd0);
        tick();
        @(negedge clk); reset = 1'b1;
        tick();
        chk("mid_rv_post", {30'b0, f_rvalid, l_rvalid}, 32'd0);
        chk("mid_rd_post", f_rdata, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
